// File: rtl/dcu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dcu_pkg
//  Description : Shared definitions for the decode-stage dependency checker:
//                opcode constants, instruction class decode, forward-select
//                width and instruction field positions.
//  Revision    : 1.0 - initial release
// ============================================================================
package dcu_pkg;

    // Width of the opcode slice that carries the class encoding
    localparam int CLS_OP_W = 5;

    localparam logic [CLS_OP_W-1:0] OPC_LD  = 5'b10100;
    localparam logic [CLS_OP_W-1:0] OPC_ST  = 5'b10101;
    localparam logic [CLS_OP_W-1:0] OPC_NOP = 5'b11111;

    typedef enum logic [2:0] {
        CLS_NOP   = 3'd0,
        CLS_ALU_R = 3'd1,
        CLS_ALU_I = 3'd2,
        CLS_LD    = 3'd3,
        CLS_ST    = 3'd4
    } ins_class_e;

    // 00xxx -> ALU_R, 01xxx -> ALU_I, exact LD/ST codes, anything else -> NOP
    function automatic ins_class_e decode_class(input logic [CLS_OP_W-1:0] op);
        ins_class_e cls;
        if (op[4:3] == 2'b00)
            cls = CLS_ALU_R;
        else if (op[4:3] == 2'b01)
            cls = CLS_ALU_I;
        else if (op == OPC_LD)
            cls = CLS_LD;
        else if (op == OPC_ST)
            cls = CLS_ST;
        else
            cls = CLS_NOP;
        return cls;
    endfunction

    // Select encodes 0 (register file) plus distances 1..depth
    function automatic int sel_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

    // Field LSB positions: op at the top, then rd, rs1, rs2; imm sits at bit 1
    function automatic int rd_lsb(input int ins_w, input int op_w, input int reg_aw);
        return ins_w - op_w - reg_aw;
    endfunction

    function automatic int rs1_lsb(input int ins_w, input int op_w, input int reg_aw);
        return ins_w - op_w - 2 * reg_aw;
    endfunction

    function automatic int rs2_lsb(input int ins_w, input int op_w, input int reg_aw);
        return ins_w - op_w - 3 * reg_aw;
    endfunction

    function automatic int imm_lsb();
        return 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dcu_slot_history.sv
`default_nettype none
// ============================================================================
//  Module      : dcu_slot_history
//  Description : Shift register of the destination info of the most recent
//                instruction slots (index 0 = distance 1). Every cycle one
//                entry (instruction or bubble) is pushed.
//  Ports       : clk, reset            - clock, sync active-high reset
//                push_*                - entry for the slot leaving decode
//                slot_valid_wr/slot_rd - all tracked slots for forwarding
//                tap1_*                - distance-1 load/store flags
//                tap2_*                - distance-2 write info and load flag
//  Revision    : 1.0 - initial release
// ============================================================================
module dcu_slot_history #(
    parameter int REG_AW = 5,
    parameter int DEPTH  = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push_valid_wr,
    input  logic [REG_AW-1:0]            push_rd,
    input  logic                         push_is_ld,
    input  logic                         push_is_st,
    output logic [DEPTH-1:0]             slot_valid_wr,
    output logic [DEPTH-1:0][REG_AW-1:0] slot_rd,
    output logic                         tap1_is_ld,
    output logic                         tap1_is_st,
    output logic                         tap2_valid_wr,
    output logic [REG_AW-1:0]            tap2_rd,
    output logic                         tap2_is_ld
);

    // At least two deep so the distance-2 tap exists even with DEPTH = 1
    localparam int HIST = (DEPTH < 2) ? 2 : DEPTH;

    logic [HIST-1:0]             r_valid_wr;
    logic [HIST-1:0][REG_AW-1:0] r_rd;
    logic [1:0]                  r_is_ld;
    logic                        r_is_st;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid_wr <= '0;
            r_rd       <= '0;
            r_is_ld    <= '0;
            r_is_st    <= 1'b0;
        end else begin
            r_valid_wr <= {r_valid_wr[HIST-2:0], push_valid_wr};
            r_rd       <= {r_rd[HIST-2:0], push_rd};
            r_is_ld    <= {r_is_ld[0], push_is_ld};
            r_is_st    <= push_is_st;
        end
    end

    assign slot_valid_wr = r_valid_wr[DEPTH-1:0];
    assign slot_rd       = r_rd[DEPTH-1:0];
    assign tap1_is_ld    = r_is_ld[0];
    assign tap1_is_st    = r_is_st;
    assign tap2_valid_wr = r_valid_wr[1];
    assign tap2_rd       = r_rd[1];
    assign tap2_is_ld    = r_is_ld[1];

endmodule
`default_nettype wire

// File: rtl/dependency_check_unit_p.sv
`default_nettype none
// ============================================================================
//  Module      : dependency_check_unit_p
//  Description : Decode-stage dependency checker. Decodes each accepted
//                instruction, forwards from the youngest matching producer
//                among FWD_DEPTH older slots, stalls on load-use and emits
//                memory control aligned to EX and DM.
//  Ports       : clk, reset, ins_valid, ins     - inputs
//                stall                          - combinational load-use hold
//                op_dec, imm, imm_sel, mux_sel_A/B - decode (accept + 1)
//                mem_en_ex, mem_rw_ex           - EX control (accept + 2)
//                RW_dm, mem_mux_sel_dm          - DM control (accept + 3)
//  Revision    : 1.0 - initial release
// ============================================================================
module dependency_check_unit_p
    import dcu_pkg::*;
#(
    parameter int OP_W      = 5,
    parameter int REG_AW    = 5,
    parameter int IMM_W     = 8,
    parameter int INS_W     = 24,
    parameter int FWD_DEPTH = 3,
    parameter int ZERO_REG  = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            ins_valid,
    input  logic [INS_W-1:0]                ins,
    output logic                            stall,
    output logic [OP_W-1:0]                 op_dec,
    output logic [IMM_W-1:0]                imm,
    output logic                            imm_sel,
    output logic [sel_width(FWD_DEPTH)-1:0] mux_sel_A,
    output logic [sel_width(FWD_DEPTH)-1:0] mux_sel_B,
    output logic                            mem_en_ex,
    output logic                            mem_rw_ex,
    output logic [REG_AW-1:0]               RW_dm,
    output logic                            mem_mux_sel_dm
);

    localparam int SW       = sel_width(FWD_DEPTH);
    localparam int C_RD_LSB = rd_lsb(INS_W, OP_W, REG_AW);
    localparam int C_R1_LSB = rs1_lsb(INS_W, OP_W, REG_AW);
    localparam int C_R2_LSB = rs2_lsb(INS_W, OP_W, REG_AW);
    localparam int C_IM_LSB = imm_lsb();

    logic [OP_W-1:0]                 w_op;
    logic [REG_AW-1:0]               w_rd, w_rs1, w_rs2, w_src_b;
    logic [IMM_W-1:0]                w_imm;
    ins_class_e                      w_cls;
    logic                            w_use_a, w_use_b, w_a_ok, w_b_ok, w_writes;
    logic                            w_hit1_a, w_hit1_b, w_stall, w_accept;
    logic [SW-1:0]                   w_sel_a, w_sel_b;
    logic [FWD_DEPTH-1:0]            w_slot_vw;
    logic [FWD_DEPTH-1:0][REG_AW-1:0] w_slot_rd;
    logic                            w_tap1_is_ld, w_tap1_is_st;
    logic                            w_tap2_vw, w_tap2_is_ld;
    logic [REG_AW-1:0]               w_tap2_rd;
    logic                            w_unused_ins;

    assign w_op    = ins[INS_W-1 -: OP_W];
    assign w_rd    = ins[C_RD_LSB +: REG_AW];
    assign w_rs1   = ins[C_R1_LSB +: REG_AW];
    assign w_rs2   = ins[C_R2_LSB +: REG_AW];
    assign w_imm   = ins[C_IM_LSB +: IMM_W];
    assign w_cls   = decode_class(w_op[OP_W-1 -: CLS_OP_W]);
    // Some instruction bits (e.g. bit 0) belong to no field for any class
    assign w_unused_ins = ^ins;

    // Stores present their data register (rd field) as the B operand
    assign w_use_a  = (w_cls != CLS_NOP);
    assign w_use_b  = (w_cls == CLS_ALU_R) || (w_cls == CLS_ST);
    assign w_src_b  = (w_cls == CLS_ST) ? w_rd : w_rs2;
    assign w_writes = (w_cls == CLS_ALU_R) || (w_cls == CLS_ALU_I) || (w_cls == CLS_LD);

    // A source that is hardwired zero never depends on anything
    assign w_a_ok = w_use_a && !((ZERO_REG != 0) && (w_rs1 == '0));
    assign w_b_ok = w_use_b && !((ZERO_REG != 0) && (w_src_b == '0));

    // Scan oldest to youngest so the nearest producer overrides
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int d = FWD_DEPTH; d >= 1; d--) begin
            if (w_slot_vw[d-1] && (w_slot_rd[d-1] == w_rs1))
                w_sel_a = SW'(d);
            if (w_slot_vw[d-1] && (w_slot_rd[d-1] == w_src_b))
                w_sel_b = SW'(d);
        end
        if (!w_a_ok)
            w_sel_a = '0;
        if (!w_b_ok)
            w_sel_b = '0;
    end

    // Load data is not ready at distance 1; hold the consumer one cycle
    assign w_hit1_a = w_a_ok && w_slot_vw[0] && (w_slot_rd[0] == w_rs1);
    assign w_hit1_b = w_b_ok && w_slot_vw[0] && (w_slot_rd[0] == w_src_b);
    assign w_stall  = !reset && ins_valid && w_tap1_is_ld && (w_hit1_a || w_hit1_b);
    assign w_accept = ins_valid && !w_stall;
    assign stall    = w_stall;

    dcu_slot_history #(
        .REG_AW (REG_AW),
        .DEPTH  (FWD_DEPTH)
    ) u_hist (
        .clk           (clk),
        .reset         (reset),
        .push_valid_wr (w_accept && w_writes),
        .push_rd       (w_accept ? w_rd : '0),
        .push_is_ld    (w_accept && (w_cls == CLS_LD)),
        .push_is_st    (w_accept && (w_cls == CLS_ST)),
        .slot_valid_wr (w_slot_vw),
        .slot_rd       (w_slot_rd),
        .tap1_is_ld    (w_tap1_is_ld),
        .tap1_is_st    (w_tap1_is_st),
        .tap2_valid_wr (w_tap2_vw),
        .tap2_rd       (w_tap2_rd),
        .tap2_is_ld    (w_tap2_is_ld)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            op_dec         <= {OP_W{1'b1}};
            imm            <= '0;
            imm_sel        <= 1'b0;
            mux_sel_A      <= '0;
            mux_sel_B      <= '0;
            mem_en_ex      <= 1'b0;
            mem_rw_ex      <= 1'b0;
            RW_dm          <= '0;
            mem_mux_sel_dm <= 1'b0;
        end else begin
            if (w_accept && (w_cls != CLS_NOP)) begin
                op_dec    <= w_op;
                imm       <= w_imm;
                imm_sel   <= (w_cls != CLS_ALU_R);
                mux_sel_A <= w_sel_a;
                mux_sel_B <= w_sel_b;
            end else begin
                op_dec    <= {OP_W{1'b1}};
                imm       <= '0;
                imm_sel   <= 1'b0;
                mux_sel_A <= '0;
                mux_sel_B <= '0;
            end
            mem_en_ex      <= w_tap1_is_ld || w_tap1_is_st;
            mem_rw_ex      <= w_tap1_is_st;
            RW_dm          <= w_tap2_vw ? w_tap2_rd : '0;
            mem_mux_sel_dm <= w_tap2_is_ld;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dependency_check_unit_p.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dependency_check_unit_p
//  Description : Self-checking bench with an independent reference model of
//                the slot history and scoreboard queues per output stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dependency_check_unit_p;

    logic        clk = 1'b0;
    logic        reset;
    logic        ins_valid;
    logic [23:0] ins;
    logic        stall;
    logic [4:0]  op_dec;
    logic [7:0]  imm;
    logic        imm_sel;
    logic [1:0]  mux_sel_A, mux_sel_B;
    logic        mem_en_ex, mem_rw_ex;
    logic [4:0]  RW_dm;
    logic        mem_mux_sel_dm;

    int errors = 0;
    int checks = 0;

    // Expected outputs: {op, imm, imm_sel, selA, selB}, {en, rw}, {rd, mux}
    logic [17:0] q_dec[$];
    logic [1:0]  q_ex[$];
    logic [5:0]  q_dm[$];

    // Reference history, index = distance
    logic       mw  [1:3];
    logic [4:0] mrd [1:3];
    logic       mld [1:3];

    always #5 clk = ~clk;

    dependency_check_unit_p #(
        .OP_W(5), .REG_AW(5), .IMM_W(8), .INS_W(24), .FWD_DEPTH(3), .ZERO_REG(1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ins_valid      (ins_valid),
        .ins            (ins),
        .stall          (stall),
        .op_dec         (op_dec),
        .imm            (imm),
        .imm_sel        (imm_sel),
        .mux_sel_A      (mux_sel_A),
        .mux_sel_B      (mux_sel_B),
        .mem_en_ex      (mem_en_ex),
        .mem_rw_ex      (mem_rw_ex),
        .RW_dm          (RW_dm),
        .mem_mux_sel_dm (mem_mux_sel_dm)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // 0 NOP, 1 ALU_R, 2 ALU_I, 3 LD, 4 ST
    function automatic int m_class(input logic [4:0] op);
        if (op[4:3] == 2'b00) return 1;
        if (op[4:3] == 2'b01) return 2;
        if (op == 5'b10100)   return 3;
        if (op == 5'b10101)   return 4;
        return 0;
    endfunction

    function automatic logic [1:0] m_sel(input logic [4:0] src);
        for (int d = 1; d <= 3; d++)
            if (mw[d] && mrd[d] == src) return 2'(d);
        return 2'd0;
    endfunction

    function automatic logic [23:0] mk_r(input logic [4:0] op, rd, rs1, rs2);
        return {op, rd, rs1, rs2, 4'b0000};
    endfunction

    function automatic logic [23:0] mk_i(input logic [4:0] op, rd, rs1, input logic [7:0] im);
        return {op, rd, rs1, im, 1'b0};
    endfunction

    task automatic model_clear();
        for (int d = 1; d <= 3; d++) begin
            mw[d] = 1'b0; mrd[d] = 5'd0; mld[d] = 1'b0;
        end
        q_dec.delete(); q_ex.delete(); q_dm.delete();
    endtask

    task automatic step(input logic v, input logic [23:0] x);
        logic [4:0]  op, rd, rs1, rs2, srcb;
        logic [17:0] e_dec;
        logic [1:0]  e_ex;
        logic [5:0]  e_dm;
        logic        ua, ub, wr, acc, exp_stall;
        int          c;
        op = x[23:19]; rd = x[18:14]; rs1 = x[13:9]; rs2 = x[8:4];
        c    = m_class(op);
        srcb = (c == 4) ? rd : rs2;
        ua   = (c != 0) && (rs1 != 5'd0);
        ub   = (c == 1 || c == 4) && (srcb != 5'd0);
        wr   = (c == 1 || c == 2 || c == 3);
        @(negedge clk);
        ins_valid = v; ins = x;
        #1;
        exp_stall = v && mld[1] && ((ua && mrd[1] == rs1) || (ub && mrd[1] == srcb));
        chk("stall", {31'd0, stall}, {31'd0, exp_stall});
        acc = v && !exp_stall;
        if (acc && c != 0)
            q_dec.push_back({op, x[8:1], (c != 1), ua ? m_sel(rs1) : 2'd0, ub ? m_sel(srcb) : 2'd0});
        else
            q_dec.push_back({5'h1f, 8'h00, 1'b0, 2'd0, 2'd0});
        q_ex.push_back({acc && (c == 3 || c == 4), acc && c == 4});
        q_dm.push_back({(acc && wr) ? rd : 5'd0, acc && c == 3});
        @(posedge clk);
        #1;
        for (int d = 3; d >= 2; d--) begin
            mw[d] = mw[d-1]; mrd[d] = mrd[d-1]; mld[d] = mld[d-1];
        end
        mw[1] = acc && wr; mrd[1] = acc ? rd : 5'd0; mld[1] = acc && c == 3;
        e_dec = q_dec.pop_front();
        chk("op_dec",    32'(op_dec),    32'(e_dec[17:13]));
        chk("imm",       32'(imm),       32'(e_dec[12:5]));
        chk("imm_sel",   32'(imm_sel),   32'(e_dec[4]));
        chk("mux_sel_A", 32'(mux_sel_A), 32'(e_dec[3:2]));
        chk("mux_sel_B", 32'(mux_sel_B), 32'(e_dec[1:0]));
        if (q_ex.size() == 2) begin
            e_ex = q_ex.pop_front();
            chk("mem_en_ex", 32'(mem_en_ex), 32'(e_ex[1]));
            chk("mem_rw_ex", 32'(mem_rw_ex), 32'(e_ex[0]));
        end
        if (q_dm.size() == 3) begin
            e_dm = q_dm.pop_front();
            chk("RW_dm",          32'(RW_dm),          32'(e_dm[5:1]));
            chk("mem_mux_sel_dm", 32'(mem_mux_sel_dm), 32'(e_dm[0]));
        end
    endtask

    task automatic do_reset(input int n, input logic v, input logic [23:0] x);
        @(negedge clk);
        reset = 1'b1; ins_valid = v; ins = x;
        #1;
        chk("stall_in_reset", 32'(stall), 32'd0);
        repeat (n) @(posedge clk);
        @(negedge clk);
        reset = 1'b0; ins_valid = 1'b0; ins = '0;
        model_clear();
        #1;
        chk("rst_op_dec",    32'(op_dec),    32'h1f);
        chk("rst_imm",       32'(imm),       32'd0);
        chk("rst_imm_sel",   32'(imm_sel),   32'd0);
        chk("rst_sel_A",     32'(mux_sel_A), 32'd0);
        chk("rst_sel_B",     32'(mux_sel_B), 32'd0);
        chk("rst_mem_en",    32'(mem_en_ex), 32'd0);
        chk("rst_mem_rw",    32'(mem_rw_ex), 32'd0);
        chk("rst_RW_dm",     32'(RW_dm),     32'd0);
        chk("rst_mem_mux",   32'(mem_mux_sel_dm), 32'd0);
        chk("rst_stall",     32'(stall),     32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] rop;
        reset = 1'b1; ins_valid = 1'b0; ins = '0;
        model_clear();
        do_reset(2, 1'b0, 24'd0);

        // Plain RAW at distance 1 on operand B
        step(1'b1, mk_r(5'b00001, 5'd4, 5'd1, 5'd2));
        step(1'b1, mk_r(5'b00010, 5'd5, 5'd1, 5'd4));

        // r4 at distances 3 and 1: youngest wins, rs1==rs2 sets both
        step(1'b1, mk_r(5'b00011, 5'd4, 5'd2, 5'd3));
        step(1'b1, mk_r(5'b00011, 5'd9, 5'd2, 5'd3));
        step(1'b1, mk_r(5'b00011, 5'd4, 5'd2, 5'd3));
        step(1'b1, mk_r(5'b00100, 5'd10, 5'd4, 5'd4));

        // Load-use: one stall cycle, then forward from distance 2
        step(1'b1, mk_i(5'b10100, 5'd4, 5'd1, 8'h00));
        step(1'b1, mk_r(5'b00001, 5'd6, 5'd4, 5'd2));
        step(1'b1, mk_r(5'b00001, 5'd6, 5'd4, 5'd2));

        // ALU_I immediate, then store of r6
        step(1'b1, mk_i(5'b01101, 5'd6, 5'd1, 8'h05));
        step(1'b1, mk_i(5'b10101, 5'd6, 5'd2, 8'h03));

        // r0 never forwards
        step(1'b1, mk_r(5'b00001, 5'd0, 5'd1, 5'd2));
        step(1'b1, mk_r(5'b00001, 5'd8, 5'd0, 5'd0));

        // Mixed random traffic including bubbles and undefined opcodes
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0:       rop = {2'b00, 3'($urandom)};
                1:       rop = {2'b01, 3'($urandom)};
                2:       rop = 5'b10100;
                3:       rop = 5'b10101;
                4:       rop = 5'b11111;
                default: rop = 5'b10110;
            endcase
            step(($urandom_range(0, 4) != 0),
                 {rop, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 4'($urandom)});
        end

        // Reset asserted while a load-use consumer is presented
        step(1'b1, mk_i(5'b10100, 5'd4, 5'd1, 8'h00));
        do_reset(1, 1'b1, mk_r(5'b00001, 5'd6, 5'd4, 5'd2));
        step(1'b1, mk_r(5'b00001, 5'd6, 5'd4, 5'd2));

        // Drain the EX/DM scoreboards
        repeat (3) step(1'b0, 24'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
